alu_param: RTL

//   Parametrised sequential ALU for the 8-bit-bus CPU datapath and its wider variants.

---
 rtl/alu_param.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_param.sv
// Parametrised sequential ALU for the CPU datapath.
// Single-cycle add/sub/logic/shift ops plus an optional iterative shift-add
// multiply. The result is held in a register and driven onto the shared bus
// when requested. Flags and a start/busy/done handshake are provided for the
// control FSM.
module alu_param #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic             enable_output,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             VF
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             r_state;
  state_e             w_state_next;

  logic [WIDTH-1:0]   r_result;
  logic               r_cf;
  logic               r_zf;
  logic               r_nf;
  logic               r_vf;
  logic               r_done;

  // Multiply working registers: accumulator, shifted multiplicand, multiplier.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_cf;
  logic               w_alu_vf;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_cf;

  logic               w_is_mul;
  logic               w_accept_mul;
  logic               w_accept_single;
  logic               w_mul_last;

  // Single-cycle operation result and carry/overflow from the live operands.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_alu_res = '0;
    w_alu_cf  = 1'b0;
    w_alu_vf  = 1'b0;
    w_sum     = '0;
    case (op)
      OP_ADD: begin
        w_sum     = {1'b0, reg_a} + {1'b0, reg_b};
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_cf  = w_sum[WIDTH];
        w_alu_vf  = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != reg_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow.
        w_sum     = {1'b0, reg_a} + {1'b0, ~reg_b} + (WIDTH+1)'(1);
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_cf  = w_sum[WIDTH];
        w_alu_vf  = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != reg_a[WIDTH-1]);
      end
      OP_AND: w_alu_res = reg_a & reg_b;
      OP_OR:  w_alu_res = reg_a | reg_b;
      OP_XOR: w_alu_res = reg_a ^ reg_b;
      OP_SHL: begin
        w_alu_res = {reg_a[WIDTH-2:0], 1'b0};
        w_alu_cf  = reg_a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, reg_a[WIDTH-1:1]};
        w_alu_cf  = reg_a[0];
      end
      default: begin
        w_alu_res = '0;
      end
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_cf   = |w_acc_next[2*WIDTH-1:WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_mul) w_state_next = S_MUL;
      S_MUL:   if (w_mul_last)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs and decoded handshake strobes.
  always_comb begin
    w_is_mul        = (op == OP_MUL);
    w_accept_mul    = (r_state == S_IDLE) && start && w_is_mul && MUL_EN;
    w_accept_single = (r_state == S_IDLE) && start && !w_accept_mul;
    w_mul_last      = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    busy            = (r_state == S_MUL);
  end

  // Result, flags, done pulse and multiply datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_nf     <= 1'b0;
      r_vf     <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept_mul) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, reg_a};
        r_mplier <= reg_b;
        r_cnt    <= '0;
      end else if (w_accept_single) begin
        // With the multiplier disabled, op 111 only pulses done.
        if (!w_is_mul) begin
          r_result <= w_alu_res;
          r_cf     <= w_alu_cf;
          r_vf     <= w_alu_vf;
          r_zf     <= (w_alu_res == '0);
          r_nf     <= w_alu_res[WIDTH-1];
        end
        r_done <= 1'b1;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_mul_last) begin
          r_result <= w_acc_next[WIDTH-1:0];
          r_cf     <= w_mul_cf;
          r_vf     <= w_mul_cf;
          r_zf     <= (w_acc_next[WIDTH-1:0] == '0);
          r_nf     <= w_acc_next[WIDTH-1];
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign bus  = enable_output ? r_result : {WIDTH{1'bz}};
  assign done = r_done;
  assign CF   = r_cf;
  assign ZF   = r_zf;
  assign NF   = r_nf;
  assign VF   = r_vf;

endmodule
